// File: rtl/brick_bag_if.sv
// brick_bag_if: handshake bundle between the game controller and brick_bag.
//   master (controller): drives take, seed_load, seed_in; reads the head brick.
//   slave  (brick_bag) : consumes take/seed controls; presents next_type,
//                        next_valid, queue_count, bag_mask.
interface brick_bag_if;
  logic        take;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [2:0]  next_type;
  logic        next_valid;
  logic [2:0]  queue_count;
  logic [6:0]  bag_mask;

  modport master (
    output take, seed_load, seed_in,
    input  next_type, next_valid, queue_count, bag_mask
  );
  modport slave (
    input  take, seed_load, seed_in,
    output next_type, next_valid, queue_count, bag_mask
  );
endinterface

// File: rtl/brick_bag.sv
// brick_bag: 7-bag brick randomiser feeding the game controller.
//   A free-running 16-bit Galois LFSR proposes types; each group of 7 pushes
//   is a permutation of 1..7. Up to QUEUE_DEPTH bricks are pre-generated so a
//   type is ready on every take; the head doubles as the preview piece.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   bus (slave)       : take (pop head), seed_load/seed_in (reseed LFSR),
//                       next_type/next_valid (head brick), queue_count,
//                       bag_mask (bit k set = type k+1 still in current bag)
// Build option: define BRICK_BAG_FIXED_EN to replace the random picker by a
//   deterministic 1,2,..,7,1,.. sequence (one push per cycle while not full).
module brick_bag #(
  parameter int          QUEUE_DEPTH = 3,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input logic       clk,
  input logic       rst,
  brick_bag_if.slave bus
);
  typedef enum logic {PICK, FULL} state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d, lfsr_adv;
  logic [2:0]  q_q [QUEUE_DEPTH];
  logic [2:0]  q_d [QUEUE_DEPTH];
  logic [2:0]  cnt_q, cnt_d, wr_idx, push_type;
  logic [6:0]  mask_q, mask_d;
  logic        pop, push, pick_en;
`ifdef BRICK_BAG_FIXED_EN
  logic [2:0]  fix_q, fix_d;
`else
  logic [3:0]  try_q, try_d;
  logic [2:0]  cand, low_type;
  logic [7:0]  mask_ext;
`endif

  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
  assign lfsr_adv = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    lfsr_d    = lfsr_adv;
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    q_d       = q_q;
    push      = 1'b0;
    push_type = 3'd0;
    wr_idx    = 3'd0;
    pop       = bus.take && (cnt_q != 3'd0);
    // a full queue may still accept a push when the head leaves this cycle
    pick_en   = (state_q == PICK) && ((cnt_q < 3'(QUEUE_DEPTH)) || pop);

    if (bus.seed_load) lfsr_d = (bus.seed_in == 16'h0) ? SEED : bus.seed_in;

`ifdef BRICK_BAG_FIXED_EN
    fix_d = fix_q;
    if (pick_en) begin
      push      = 1'b1;
      push_type = fix_q;
      fix_d     = (fix_q == 3'd7) ? 3'd1 : fix_q + 3'd1;
    end
`else
    try_d    = try_q;
    cand     = lfsr_q[2:0];
    mask_ext = {mask_q, 1'b0};      // index 0 never available
    low_type = 3'd1;
    for (int k = 6; k >= 0; k--)
      if (mask_q[k]) low_type = 3'(k + 1);
    if (pick_en) begin
      if (mask_ext[cand]) begin
        push      = 1'b1;
        push_type = cand;
      end else if (try_q == 4'd8) begin
        push      = 1'b1;
        push_type = low_type;
      end else begin
        try_d = try_q + 4'd1;
      end
    end
    if (push) try_d = 4'd0;
`endif

    if (pop) begin
      for (int i = 0; i < QUEUE_DEPTH - 1; i++) q_d[i] = q_q[i + 1];
      q_d[QUEUE_DEPTH-1] = 3'd0;
    end
    if (push) begin
      wr_idx = cnt_q - {2'b0, pop};
      for (int i = 0; i < QUEUE_DEPTH; i++)
        if (3'(i) == wr_idx) q_d[i] = push_type;
      for (int k = 0; k < 7; k++)
        if (push_type == 3'(k + 1)) mask_d[k] = 1'b0;
      // last type of the bag drawn: next bag starts on the same edge
      if (mask_d == 7'h00) mask_d = 7'h7F;
    end
    cnt_d = cnt_q + {2'b0, push} - {2'b0, pop};

    if (pop)                                        state_d = PICK;
    else if (push && cnt_d == 3'(QUEUE_DEPTH))      state_d = FULL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PICK;
      lfsr_q  <= SEED;
      cnt_q   <= 3'd0;
      mask_q  <= 7'h7F;
      for (int i = 0; i < QUEUE_DEPTH; i++) q_q[i] <= 3'd0;
`ifdef BRICK_BAG_FIXED_EN
      fix_q   <= 3'd1;
`else
      try_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      q_q     <= q_d;
`ifdef BRICK_BAG_FIXED_EN
      fix_q   <= fix_d;
`else
      try_q   <= try_d;
`endif
    end
  end

  assign bus.next_valid  = (cnt_q != 3'd0);
  assign bus.next_type   = (cnt_q != 3'd0) ? q_q[0] : 3'd0;
  assign bus.queue_count = cnt_q;
  assign bus.bag_mask    = mask_q;
endmodule

// File: tb/tb_brick_bag.sv
module tb_brick_bag;
  localparam int          D    = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  brick_bag_if bus ();
  brick_bag #(.QUEUE_DEPTH(D), .SEED(SEED)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of types + bag set ----------------
  int          mq[$];
  bit          mbag[1:7];
  int          mtries, mfix;
  bit          mfull;
  logic [15:0] mlfsr;

  function automatic int m_lowest();
    for (int t = 1; t <= 7; t++) if (mbag[t]) return t;
    return 0;
  endfunction

  function automatic logic [15:0] m_mask();
    logic [15:0] m = 0;
    for (int t = 1; t <= 7; t++) m[t-1] = mbag[t];
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit pop, push;
    int t, cand;
    if (rst) begin
      mq.delete();
      for (int k = 1; k <= 7; k++) mbag[k] = 1;
      mtries = 0; mfull = 0; mlfsr = SEED; mfix = 1;
    end else begin
      pop  = bus.take && (mq.size() > 0);
      push = 0; t = 0;
      if (!mfull && (mq.size() < D || pop)) begin
`ifdef BRICK_BAG_FIXED_EN
        push = 1; t = mfix; mfix = (mfix == 7) ? 1 : mfix + 1;
`else
        cand = int'(mlfsr % 8);
        if (cand != 0 && mbag[cand]) begin push = 1; t = cand; end
        else if (mtries == 8)        begin push = 1; t = m_lowest(); end
        else mtries++;
`endif
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(t);
        mbag[t] = 0;
        mtries = 0;
        if (m_lowest() == 0) for (int k = 1; k <= 7; k++) mbag[k] = 1;
      end
      if (pop) mfull = 0;
      else if (push && mq.size() >= D) mfull = 1;
      if (bus.seed_load) mlfsr = (bus.seed_in == 0) ? SEED : bus.seed_in;
      else begin
        if (mlfsr[0]) mlfsr = (mlfsr >> 1) ^ 16'hB400;
        else          mlfsr = mlfsr >> 1;
      end
    end
  end

  // ---------------- monitor: compare presented head against model ----------
  int taken[$];
  always @(negedge clk) begin
    if (!rst) begin
      chk("next_valid", 16'(bus.next_valid), 16'(mq.size() > 0));
      chk("next_type", 16'(bus.next_type), (mq.size() > 0) ? 16'(mq[0]) : 16'h0);
      chk("queue_count", 16'(bus.queue_count), 16'(mq.size()));
      chk("bag_mask", 16'(bus.bag_mask), m_mask());
      if (bus.take && bus.next_valid) taken.push_back(int'(bus.next_type));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic take_pulse(int gap);
    bus.take = 1'b1; tick(1); bus.take = 1'b0; tick(gap - 1);
  endtask

  task automatic chk_perm(string nm, int start);
    logic [15:0] seen = 0;
    for (int i = 0; i < 7; i++)
      if (start + i < taken.size() && taken[start+i] >= 1 && taken[start+i] <= 7)
        seen[taken[start+i]-1] = 1'b1;
    chk(nm, seen, 16'h007F);
  endtask

  task automatic reset_async_chk();
    rst = 1'b1; #1;
    chk("rst_next_valid", 16'(bus.next_valid), 16'h0);
    chk("rst_next_type", 16'(bus.next_type), 16'h0);
    chk("rst_queue_count", 16'(bus.queue_count), 16'h0);
    chk("rst_bag_mask", 16'(bus.bag_mask), 16'h7F);
    tick(1); rst = 1'b0;
  endtask

  task automatic seed_run(logic [15:0] s, output int seq[$]);
    int st;
    reset_async_chk();
    tick(3);
    bus.seed_load = 1'b1; bus.seed_in = s; tick(1);
    bus.seed_load = 1'b0;
    tick(20);
    st = taken.size();
    repeat (14) take_pulse(12);
    seq.delete();
    for (int i = st; i < taken.size(); i++) seq.push_back(taken[i]);
  endtask

  int s_a[$], s_b[$], s_z[$], s_s[$];
  int n, st;

  initial begin
    bus.take = 1'b0; bus.seed_load = 1'b0; bus.seed_in = 16'h0;
    tick(2);
    reset_async_chk();
    // take while the queue is still empty is ignored
    bus.take = 1'b1;
    n = 0;
    @(posedge clk); #1;
    bus.take = 1'b0;
    while (!bus.next_valid && n < 12) begin tick(1); n++; end
    chk("first_valid_within_9", 16'(n <= 8), 16'h1);
    tick(40);
    chk("idle_full_count", 16'(bus.queue_count), 16'(D));
    chk("idle_valid", 16'(bus.next_valid), 16'h1);

`ifdef BRICK_BAG_FIXED_EN
    st = taken.size();
    repeat (10) take_pulse(3);
    for (int i = 0; i < 10; i++)
      chk("fixed_seq", (st + i < taken.size()) ? 16'(taken[st+i]) : 16'hFFFF, 16'((i % 7) + 1));
    take_pulse(3);
    reset_async_chk();
    tick(4);
    st = taken.size();
    take_pulse(3);
    chk("fixed_restart", (st < taken.size()) ? 16'(taken[st]) : 16'hFFFF, 16'h1);
`else
    // 7 + 70 takes from reset: aligned groups of 7 are permutations
    repeat (77) take_pulse(12);
    chk("take_total", 16'(taken.size()), 16'd77);
    for (int g = 0; g < 11; g++) chk_perm("bag_perm", g * 7);
    // back-to-back takes: pops coincide with pushes
    repeat (3) take_pulse(1);
    tick(12);
    chk("refill_count", 16'(bus.queue_count), 16'(D));
    // seed reproducibility
    seed_run(16'h1234, s_a);
    seed_run(16'h1234, s_b);
    seed_run(16'h0000, s_z);
    seed_run(SEED, s_s);
    for (int i = 0; i < 14; i++) begin
      chk("seed_repeat", (i < s_b.size()) ? 16'(s_b[i]) : 16'hFFFF,
                         (i < s_a.size()) ? 16'(s_a[i]) : 16'hEEEE);
      chk("seed_zero", (i < s_z.size()) ? 16'(s_z[i]) : 16'hFFFF,
                       (i < s_s.size()) ? 16'(s_s[i]) : 16'hEEEE);
    end
`endif
    // randomized traffic, including reseeds
    for (int c = 0; c < 1500; c++) begin
      bus.take      = ($urandom_range(0, 3) == 0);
      bus.seed_load = ($urandom_range(0, 49) == 0);
      bus.seed_in   = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
      tick(1);
    end
    bus.take = 1'b0; bus.seed_load = 1'b0;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
